// File: rtl/stage_mem_lsu.sv
// MEM stage: EX/MEM register, load/store unit with req/ack data port,
// and MEM/WB register. Stalls upstream while an access is outstanding.
module stage_mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    output logic        mem_stall,
    output logic [4:0]  EX_MEM_rd,
    output logic        EX_MEM_RegWrite,
    output logic [31:0] EX_MEM_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } ex_mem_t;

    function automatic logic misalign(input logic [2:0] f3,
                                      input logic [1:0] a);
        return (f3[1:0] == 2'b01 && a[0]) ||
               (f3[1:0] == 2'b10 && a != 2'b00);
    endfunction

    ex_mem_t       exm;
    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          tmo_q;

    logic        ex_go;
    logic        cnt_last;
    logic        m_load, m_store, m_err;
    logic        is_w, is_h;
    logic [31:0] sh, ld_val, wdata;
    logic [3:0]  wstrb;

    assign ex_go = ex_valid & (ex_mem_read | ex_mem_write) &
                   ~misalign(ex_funct3, ex_alu_result[1:0]);
    assign cnt_last = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            exm <= '0;
        end else if (!mem_stall) begin
            if (ex_valid)
                exm <= '{1'b1, ex_mem_read, ex_mem_write, ex_funct3,
                         ex_alu_result, ex_store_data, ex_rd,
                         ex_reg_write, ex_mem_to_reg};
            else
                exm <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        unique case (state)
            ACCESS:  state_nx = (dmem_ack || cnt_last) ? DONE : ACCESS;
            default: state_nx = ex_go ? ACCESS : IDLE;
        endcase
    end

    always_comb begin
        mem_stall = (state == ACCESS);
        dmem_req  = (state == ACCESS);
    end

    // An ack on the final wait cycle still counts as success.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else if (state == ACCESS) begin
            cnt <= cnt + 1'b1;
            if (dmem_ack) begin
                rdata_q <= dmem_rdata;
                tmo_q   <= 1'b0;
            end else if (cnt_last) begin
                tmo_q <= 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign m_load  = exm.valid & exm.mem_read;
    assign m_store = exm.valid & exm.mem_write & ~exm.mem_read;
    assign m_err   = ((m_load | m_store) &
                      misalign(exm.funct3, exm.addr[1:0])) |
                     (state == DONE & tmo_q);
    assign is_w    = (exm.funct3[1:0] == 2'b10);
    assign is_h    = (exm.funct3[1:0] == 2'b01);
    assign sh      = rdata_q >> {exm.addr[1:0], 3'b000};

    always_comb begin
        wstrb  = 4'b0001 << exm.addr[1:0];
        wdata  = {4{exm.sdata[7:0]}};
        ld_val = exm.funct3[2] ? {24'b0, sh[7:0]}
                               : {{24{sh[7]}}, sh[7:0]};
        unique case (1'b1)
            is_w: begin
                wstrb  = 4'b1111;
                wdata  = exm.sdata;
                ld_val = rdata_q;
            end
            is_h: begin
                wstrb  = 4'b0011 << exm.addr[1:0];
                wdata  = {2{exm.sdata[15:0]}};
                ld_val = exm.funct3[2] ? {16'b0, sh[15:0]}
                                       : {{16{sh[15]}}, sh[15:0]};
            end
            default: ;
        endcase
    end

    assign dmem_addr  = dmem_req ? {exm.addr[31:2], 2'b00} : '0;
    assign dmem_we    = dmem_req & m_store;
    assign dmem_wstrb = dmem_we ? wstrb : '0;
    assign dmem_wdata = dmem_we ? wdata : '0;

    assign EX_MEM_rd       = exm.rd;
    assign EX_MEM_RegWrite = exm.valid & exm.reg_write & ~exm.mem_to_reg;
    assign EX_MEM_data     = exm.addr;

    always_ff @(posedge clk) begin
        if (rst || state == ACCESS) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid     <= exm.valid;
            wb_rd        <= exm.rd;
            wb_reg_write <= exm.valid & exm.reg_write & ~m_store & ~m_err;
            wb_data      <= exm.mem_to_reg ? ld_val : exm.addr;
            mem_err      <= exm.valid & m_err;
        end
    end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Randomized bench for stage_mem_lsu: byte-level memory reference model,
// in-order writeback scoreboard and a req/ack memory responder.
module tb_stage_mem_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_to_reg;
    logic        mem_stall;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_RegWrite;
    logic [31:0] EX_MEM_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic        wb_valid, wb_reg_write, mem_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    stage_mem_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .mem_stall(mem_stall),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_data(EX_MEM_data), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .mem_err(mem_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        err;
        logic [31:0] data;
        logic        cd;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } acc_t;

    wb_t         wbq[$];
    acc_t        accq[$];
    logic [31:0] mem[16];
    logic [31:0] ref_mem[16];
    int          ack_mode;
    logic        exp_tmo;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        mem[a[5:2]] = w;
        ref_mem[a[5:2]] = w;
    endtask

    // Architectural effect of one instruction, computed byte by byte.
    task automatic model(input logic v, input logic rd_en,
                         input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic rw,
                         input logic m2r);
        int s = size_of(f3);
        int off = int'(a % 4);
        int idx = int'((a / 4) % 16);
        logic ld = rd_en;
        logic st = wr_en && !rd_en;
        logic mis = (ld || st) && ((a % 32'(s)) != 0);
        logic [31:0] val = 0;
        wb_t e;
        acc_t x;
        if (!v) return;
        if (ld) begin
            val = ref_mem[idx] >> (8 * off);
            if (s == 1) begin
                val = val & 32'hFF;
                if (!f3[2] && val >= 32'h80) val = val + 32'hFFFFFF00;
            end else if (s == 2) begin
                val = val & 32'hFFFF;
                if (!f3[2] && val >= 32'h8000) val = val + 32'hFFFF0000;
            end
        end
        e.err = mis || ((ld || st) && exp_tmo);
        e.rd = rd;
        e.rw = rw && !st && !e.err;
        e.data = m2r ? val : a;
        e.cd = !(m2r && e.err);
        if ((ld || st) && !mis) begin
            x.addr = a - 32'(off);
            x.we = st;
            x.strb = 4'(((1 << s) - 1) << off);
            for (int i = 0; i < 4; i++)
                x.wdata[8*i +: 8] = d[8*(i % s) +: 8];
            accq.push_back(x);
            if (st && !exp_tmo)
                for (int i = 0; i < s; i++)
                    ref_mem[idx][8*(off+i) +: 8] = d[8*i +: 8];
        end
        wbq.push_back(e);
    endtask

    // Called #1 after a posedge; returns #1 after the edge that loads it.
    task automatic issue(input logic v, input logic rd_en,
                         input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic rw,
                         input logic m2r);
        logic s;
        int g = 0;
        model(v, rd_en, wr_en, f3, a, d, rd, rw, m2r);
        ex_valid = v;
        ex_mem_read = rd_en;
        ex_mem_write = wr_en;
        ex_funct3 = f3;
        ex_alu_result = a;
        ex_store_data = d;
        ex_rd = rd;
        ex_reg_write = rw;
        ex_mem_to_reg = m2r;
        do begin
            @(negedge clk);
            s = mem_stall;
            @(posedge clk);
            #1;
            g++;
        end while (s && g < 100);
        if (s) check("issue_stuck", 32'(s), 0);
    endtask

    task automatic drain(output int n);
        n = 0;
        ex_valid = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (!mem_stall) break;
            n++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    wb_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (wbq.size() == 0) begin
                    check("wb_unexpected_valid", 32'(wb_valid), 0);
                end else begin
                    mon_e = wbq.pop_front();
                    check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                    check("wb_reg_write", 32'(wb_reg_write), 32'(mon_e.rw));
                    check("mem_err", 32'(mem_err), 32'(mon_e.err));
                    if (mon_e.cd) check("wb_data", wb_data, mon_e.data);
                end
            end else begin
                check("mem_err_idle", 32'(mem_err), 0);
            end
        end
    end

    acc_t cur;
    logic cur_ok;
    int   wcnt, dly;
    initial begin
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        wcnt = 0;
        dly = 0;
        cur_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!dmem_req) begin
                dmem_ack = 1'b0;
                wcnt = 0;
            end else begin
                if (wcnt == 0) begin
                    if (accq.size() == 0) begin
                        check("dmem_req_unexpected", 32'(dmem_req), 0);
                        cur_ok = 1'b0;
                    end else begin
                        cur = accq.pop_front();
                        cur_ok = 1'b1;
                    end
                    dly = (ack_mode < 0) ? int'($urandom_range(0, 3))
                                         : ack_mode;
                end
                if (cur_ok) begin
                    check("dmem_addr", dmem_addr, cur.addr);
                    check("dmem_we", 32'(dmem_we), 32'(cur.we));
                    if (cur.we) begin
                        check("dmem_wstrb", 32'(dmem_wstrb), 32'(cur.strb));
                        check("dmem_wdata", dmem_wdata, cur.wdata);
                    end
                end
                if (wcnt == dly) begin
                    for (int b = 0; b < 4; b++)
                        if (dmem_we && dmem_wstrb[b])
                            mem[dmem_addr[5:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                    dmem_rdata = mem[dmem_addr[5:2]];
                    dmem_ack = 1'b1;
                end else begin
                    dmem_ack = 1'b0;
                    dmem_rdata = $urandom;
                end
                wcnt++;
            end
        end
    end

    int          n;
    int          t;
    logic [2:0]  ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] ra;

    initial begin
        rst = 1'b1;
        ack_mode = 0;
        exp_tmo = 1'b0;
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
        ex_alu_result = 0; ex_store_data = 0; ex_rd = 0;
        ex_reg_write = 0; ex_mem_to_reg = 0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(mem_stall), 0);
        check("rst_req", 32'(dmem_req), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_fwd_rw", 32'(EX_MEM_RegWrite), 0);
        check("rst_fwd_data", EX_MEM_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(1, 0, 0, 3'b000, 32'h5, 32'h0, 5'd3, 1, 0);
        ex_valid = 1'b0;
        @(negedge clk);
        check("add_fwd_rd", 32'(EX_MEM_rd), 3);
        check("add_fwd_rw", 32'(EX_MEM_RegWrite), 1);
        check("add_fwd_data", EX_MEM_data, 32'h5);
        check("add_stall", 32'(mem_stall), 0);
        @(posedge clk);
        @(negedge clk);
        check("add_latency", 32'(wb_valid), 1);
        @(posedge clk);
        #1;

        poke(32'h1003, 32'h80AABBCC);
        ack_mode = 2;
        issue(1, 1, 0, 3'b000, 32'h1003, 32'h0, 5'd5, 1, 1);
        drain(n);
        check("lb_stall_cycles", 32'(n), 3);

        ack_mode = 0;
        issue(1, 0, 1, 3'b001, 32'h2002, 32'h1234ABCD, 5'd6, 1, 0);
        drain(n);
        check("sh_stall_cycles", 32'(n), 1);

        issue(1, 1, 0, 3'b010, 32'h3001, 32'h0, 5'd7, 1, 1);
        drain(n);
        check("misaligned_stall", 32'(n), 0);

        ack_mode = 1000;
        exp_tmo = 1'b1;
        issue(1, 1, 0, 3'b010, 32'h3000, 32'h0, 5'd8, 1, 1);
        drain(n);
        check("timeout_cycles", 32'(n), TO);
        exp_tmo = 1'b0;
        ack_mode = -1;

        for (int k = 0; k < 300; k++) begin
            t = int'($urandom_range(0, 9));
            ra = 32'h1000 | 32'($urandom_range(0, 63));
            if (t < 3)
                issue(1, 0, 0, 3'($urandom_range(0, 7)), $urandom,
                      $urandom, 5'($urandom_range(0, 31)), 1, 0);
            else if (t < 6)
                issue(1, 1, 1'($urandom_range(0, 3) == 0),
                      ld_f3[$urandom_range(0, 4)], ra, $urandom,
                      5'($urandom_range(0, 31)), 1, 1);
            else if (t < 9)
                issue(1, 0, 1, 3'($urandom_range(0, 2)), ra, $urandom,
                      5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 0);
            else
                issue(0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      ra, $urandom, 5'($urandom_range(0, 31)), 1, 1);
        end
        drain(n);
        repeat (3) @(posedge clk);
        #1;
        check("wb_queue_left", 32'(wbq.size()), 0);

        poke(32'h4000, 32'hBEEF1234);
        ack_mode = 1;
        issue(1, 1, 0, 3'b101, 32'h4002, 32'h0, 5'd9, 1, 1);
        @(negedge clk);
        #1;
        ack_mode = 1000;
        issue(1, 0, 1, 3'b010, 32'h4004, 32'hCAFEF00D, 5'd10, 0, 0);
        ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_access_req", 32'(dmem_req), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wbq.delete();
        accq.delete();
        @(negedge clk);
        check("post_rst_req", 32'(dmem_req), 0);
        check("post_rst_stall", 32'(mem_stall), 0);
        check("post_rst_wb_valid", 32'(wb_valid), 0);
        check("post_rst_wb_rd", 32'(wb_rd), 0);
        check("post_rst_wb_rw", 32'(wb_reg_write), 0);
        check("post_rst_wb_data", wb_data, 0);
        check("post_rst_err", 32'(mem_err), 0);
        ack_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
